// File: rtl/range_counter_arbiter.sv
// range_counter_arbiter: round-robin command front-end sharing one MIN..MAX wrap-around counter between two requesters
module range_counter_arbiter #(
  parameter int WIDTH = 8,
  parameter int MIN   = 10,
  parameter int MAX   = 40,
  parameter int STEPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       cmd0,
  input  logic [WIDTH-1:0] data0,
  input  logic [STEPW-1:0] steps0,
  input  logic             req1,
  input  logic [1:0]       cmd1,
  input  logic [WIDTH-1:0] data1,
  input  logic [STEPW-1:0] steps1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             done_id
);
  localparam logic [1:0] S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2;
  localparam logic [1:0] C_LOAD = 2'b00, C_UP = 2'b01, C_CLEAR = 2'b11;
  localparam logic [WIDTH-1:0] L_MIN = WIDTH'(MIN), L_MAX = WIDTH'(MAX), L_ONE = WIDTH'(1);
  localparam logic [STEPW-1:0] L_S1 = STEPW'(1);
  logic [1:0]       r_state, r_cmd;
  logic             r_last, r_id, r_gnt0, r_gnt1;
  logic [WIDTH-1:0] r_data, r_count, w_next;
  logic [STEPW-1:0] r_rem;
  logic             w_pick, w_inr, w_din, w_upd, w_last;
  // on a tie the requester that did not win last time gets the grant
  assign w_pick = (req0 & req1) ? ~r_last : req1;
  assign w_inr  = r_count >= L_MIN && r_count <= L_MAX;
  assign w_din  = r_data >= L_MIN && r_data <= L_MAX;
  // LOAD and CLEAR (equal opcode bits) take one cycle regardless of steps
  assign w_last = r_cmd[0] == r_cmd[1] || r_rem <= L_S1;
  assign w_upd  = r_cmd[0] == r_cmd[1] || r_rem != '0;
  always_comb begin
    w_next = r_cmd == C_LOAD ? (w_din ? r_data : L_MIN) :
             r_cmd == C_CLEAR || !w_inr ? L_MIN :
             r_cmd == C_UP ? (r_count == L_MAX ? L_MIN : r_count + L_ONE) :
             (r_count == L_MIN ? L_MAX : r_count - L_ONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= L_MIN;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_cmd   <= C_LOAD;
      r_data  <= '0;
      r_rem   <= '0;
    end else begin
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      if (r_state == S_IDLE) begin
        if (req0 | req1) begin
          r_state <= S_EXEC;
          r_gnt0  <= ~w_pick;
          r_gnt1  <= w_pick;
          r_last  <= w_pick;
          r_id    <= w_pick;
          r_cmd   <= w_pick ? cmd1 : cmd0;
          r_data  <= w_pick ? data1 : data0;
          r_rem   <= w_pick ? steps1 : steps0;
        end
      end else if (r_state == S_EXEC) begin
        if (w_upd) r_count <= w_next;
        if (w_last) r_state <= S_DONE;
        else r_rem <= r_rem - L_S1;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end
  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign count   = r_count;
  assign busy    = r_state != S_IDLE;
  assign done    = r_state == S_DONE;
  assign done_id = r_id;
endmodule

// File: tb/tb_range_counter_arbiter.sv
// tb_range_counter_arbiter: directed self-checking bench for range_counter_arbiter
module tb_range_counter_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] cmd0 = 2'b00, cmd1 = 2'b00;
  logic [7:0] data0 = '0, data1 = '0;
  logic [3:0] steps0 = '0, steps1 = '0;
  logic       gnt0, gnt1, busy, done, done_id;
  logic [7:0] count;
  int n_chk = 0, n_fail = 0;
  localparam logic [1:0] LOAD = 2'b00, UP = 2'b01, DOWN = 2'b10, CLEAR = 2'b11;

  range_counter_arbiter #(.WIDTH(8), .MIN(10), .MAX(40), .STEPW(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .cmd0(cmd0), .data0(data0), .steps0(steps0),
    .req1(req1), .cmd1(cmd1), .data1(data1), .steps1(steps1),
    .gnt0(gnt0), .gnt1(gnt1), .count(count), .busy(busy), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // present a command in IDLE, wait for the grant cycle, then drop the request
  task automatic issue(input bit id, input logic [1:0] c, input logic [7:0] d, input logic [3:0] s);
    if (id) begin req1 = 1'b1; cmd1 = c; data1 = d; steps1 = s; end
    else begin req0 = 1'b1; cmd0 = c; data0 = d; steps0 = s; end
    step();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_chk++; if (count !== 8'd10) begin n_fail++; $display("FAIL reset_count: got %0d exp 10", count); end
    n_chk++; if ({busy, gnt0, gnt1, done, done_id} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: busy/gnt0/gnt1/done/id got %b exp 00000", {busy, gnt0, gnt1, done, done_id}); end
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    n_chk++; if (count !== 8'd10 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_pulse: count=%0d busy=%b exp 10/0", count, busy); end
  endtask

  task automatic test_load_up();
    logic [7:0] e [4] = '{8'd39, 8'd40, 8'd10, 8'd11};
    issue(1'b0, LOAD, 8'd38, 4'd0);
    n_chk++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL load_grant: gnt0=%b gnt1=%b busy=%b exp 1/0/1", gnt0, gnt1, busy); end
    step();
    n_chk++; if (count !== 8'd38 || done !== 1'b1 || done_id !== 1'b0 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL load_done: count=%0d done=%b id=%b gnt0=%b exp 38/1/0/0", count, done, done_id, gnt0); end
    step();
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL load_idle: busy=%b done=%b exp 0/0", busy, done); end
    issue(1'b0, UP, 8'd0, 4'd4);
    n_chk++; if (gnt0 !== 1'b1 || count !== 8'd38) begin n_fail++; $display("FAIL up_grant: gnt0=%b count=%0d exp 1/38", gnt0, count); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_chk++; if (count !== e[i] || done !== (i == 3)) begin n_fail++; $display("FAIL up_step%0d: count=%0d done=%b exp %0d/%b", i, count, done, e[i], i == 3); end
    end
    n_chk++; if (done_id !== 1'b0) begin n_fail++; $display("FAIL up_done_id: got %b exp 0", done_id); end
    step();
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL up_idle: busy=%b done=%b exp 0/0", busy, done); end
  endtask

  task automatic test_down_load_range();
    do_reset();
    issue(1'b1, DOWN, 8'd0, 4'd2);
    n_chk++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL down_grant: gnt0=%b gnt1=%b exp 0/1", gnt0, gnt1); end
    step();
    n_chk++; if (count !== 8'd40 || done !== 1'b0) begin n_fail++; $display("FAIL down_wrap: count=%0d done=%b exp 40/0", count, done); end
    step();
    n_chk++; if (count !== 8'd39 || done !== 1'b1 || done_id !== 1'b1) begin n_fail++; $display("FAIL down_done: count=%0d done=%b id=%b exp 39/1/1", count, done, done_id); end
    step();
    issue(1'b1, LOAD, 8'd50, 4'd0);
    step();
    n_chk++; if (count !== 8'd10) begin n_fail++; $display("FAIL load_over: count=%0d exp 10", count); end
    step();
    issue(1'b1, LOAD, 8'd40, 4'd0);
    step();
    n_chk++; if (count !== 8'd40) begin n_fail++; $display("FAIL load_max: count=%0d exp 40", count); end
    step();
    issue(1'b1, LOAD, 8'd9, 4'd0);
    step();
    n_chk++; if (count !== 8'd10) begin n_fail++; $display("FAIL load_under: count=%0d exp 10", count); end
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    req0 = 1'b1; cmd0 = UP; steps0 = 4'd1;
    req1 = 1'b1; cmd1 = UP; steps1 = 4'd1;
    step();
    req0 = 1'b0;
    n_chk++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL rr_first: gnt0=%b gnt1=%b exp 1/0", gnt0, gnt1); end
    step();
    n_chk++; if (count !== 8'd11 || done !== 1'b1 || done_id !== 1'b0) begin n_fail++; $display("FAIL rr_first_done: count=%0d done=%b id=%b exp 11/1/0", count, done, done_id); end
    step();
    n_chk++; if (busy !== 1'b0 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL rr_wait: busy=%b gnt1=%b exp 0/0", busy, gnt1); end
    step();
    req1 = 1'b0;
    n_chk++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL rr_second: gnt0=%b gnt1=%b exp 0/1", gnt0, gnt1); end
    step();
    n_chk++; if (count !== 8'd12 || done !== 1'b1 || done_id !== 1'b1) begin n_fail++; $display("FAIL rr_second_done: count=%0d done=%b id=%b exp 12/1/1", count, done, done_id); end
    step();
    req0 = 1'b1;
    req1 = 1'b1;
    step();
    req0 = 1'b0;
    req1 = 1'b0;
    n_chk++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL rr_alternate: gnt0=%b gnt1=%b exp 1/0", gnt0, gnt1); end
    step();
    n_chk++; if (count !== 8'd13 || done_id !== 1'b0) begin n_fail++; $display("FAIL rr_alt_done: count=%0d id=%b exp 13/0", count, done_id); end
    step();
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    req0 = 1'b1; cmd0 = UP; steps0 = 4'd15;
    step();
    n_chk++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL mid_grant: gnt0=%b exp 1", gnt0); end
    for (int i = 0; i < 4; i++) step();
    n_chk++; if (count !== 8'd14 || busy !== 1'b1) begin n_fail++; $display("FAIL mid_progress: count=%0d busy=%b exp 14/1", count, busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_chk++; if (count !== 8'd10 || busy !== 1'b0 || done !== 1'b0 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL mid_reset: count=%0d busy=%b done=%b gnt0=%b exp 10/0/0/0", count, busy, done, gnt0); end
    step();
    req0 = 1'b0;
    n_chk++; if (gnt0 !== 1'b1 || count !== 8'd10) begin n_fail++; $display("FAIL mid_regrant: gnt0=%b count=%0d exp 1/10", gnt0, count); end
    do_reset();
  endtask

  task automatic test_zero_step_clear();
    do_reset();
    issue(1'b0, LOAD, 8'd25, 4'd0);
    step();
    step();
    n_chk++; if (count !== 8'd25 || busy !== 1'b0) begin n_fail++; $display("FAIL zs_setup: count=%0d busy=%b exp 25/0", count, busy); end
    issue(1'b0, UP, 8'd0, 4'd0);
    n_chk++; if (gnt0 !== 1'b1 || count !== 8'd25) begin n_fail++; $display("FAIL zs_grant: gnt0=%b count=%0d exp 1/25", gnt0, count); end
    step();
    n_chk++; if (count !== 8'd25 || done !== 1'b1) begin n_fail++; $display("FAIL zs_done: count=%0d done=%b exp 25/1", count, done); end
    step();
    issue(1'b1, CLEAR, 8'd0, 4'd7);
    n_chk++; if (busy !== 1'b1 || gnt1 !== 1'b1) begin n_fail++; $display("FAIL clr_busy1: busy=%b gnt1=%b exp 1/1", busy, gnt1); end
    step();
    n_chk++; if (busy !== 1'b1 || done !== 1'b1 || count !== 8'd10 || done_id !== 1'b1) begin n_fail++; $display("FAIL clr_done: busy=%b done=%b count=%0d id=%b exp 1/1/10/1", busy, done, count, done_id); end
    step();
    n_chk++; if (busy !== 1'b0 || count !== 8'd10) begin n_fail++; $display("FAIL clr_idle: busy=%b count=%0d exp 0/10", busy, count); end
  endtask

  initial begin
    test_reset();
    test_load_up();
    test_down_load_range();
    test_round_robin();
    test_reset_mid_exec();
    test_zero_step_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
